ram_file_address_unit: RTL

Parametrised, registered RAM file address generator for the PIC16F-style core. It holds the FSR register internally and detects INDF accesses (opcode address 0) to select indirect addressing automatically. It supports FSR post-increment, post-decrement and pre-increment modes, and folds the common (unbanked) RAM window onto bank 0. It sits between the instruction decoder / STATUS register and the RAM file, and presents one registered address per access request.

---
 rtl/ram_file_address_unit.sv | 58 +++++
 1 files changed

// File: rtl/ram_file_address_unit.sv
// ram_file_address_unit: registered RAM file address generator with FSR, INDF detection and common-window folding
module ram_file_address_unit #(
   parameter int OPC_ADDR_W = 7,
   parameter int BANK_W = 2,
   parameter int IBANK_W = 1,
   parameter int FSR_W = 8,
   parameter int COMMON_EN = 1,
   parameter logic [OPC_ADDR_W-1:0] COMMON_BASE = 7'h70
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         addr_req,
   input  logic [OPC_ADDR_W-1:0]        opcode_address,
   input  logic [BANK_W-1:0]            status_rp,
   input  logic [IBANK_W-1:0]           status_irp,
   input  logic [1:0]                   fsr_mode,
   input  logic                         fsr_wr_en,
   input  logic [FSR_W-1:0]             fsr_wr_data,
   output logic [FSR_W-1:0]             fsr,
   output logic [BANK_W+OPC_ADDR_W-1:0] ram_file_address,
   output logic                         addr_valid,
   output logic                         indirect,
   output logic                         null_access,
   output logic                         fsr_wrap
);
   localparam int AW = BANK_W + OPC_ADDR_W;
   logic ind, dec, upd, fold, wrap;
   logic [FSR_W-1:0] eff, nxt;
   logic [AW-1:0] raw, addr;
   always_comb begin
      ind = opcode_address == '0;
      dec = fsr_mode == 2'b10;
      eff = fsr_mode == 2'b11 ? fsr + FSR_W'(1) : fsr;
      raw = ind ? {status_irp, eff} : {status_rp, opcode_address};
      fold = COMMON_EN != 0 && raw[OPC_ADDR_W-1:0] >= COMMON_BASE;
      addr = fold ? {{BANK_W{1'b0}}, raw[OPC_ADDR_W-1:0]} : raw;
      upd = addr_req && ind && fsr_mode != 2'b00 && !fsr_wr_en;
      nxt = dec ? fsr - FSR_W'(1) : fsr + FSR_W'(1);
      wrap = upd && (dec ? fsr == '0 : fsr == '1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         fsr <= '0;
         ram_file_address <= '0;
         addr_valid <= 1'b0;
         indirect <= 1'b0;
         null_access <= 1'b0;
         fsr_wrap <= 1'b0;
      end else begin
         addr_valid <= addr_req;
         indirect <= addr_req && ind;
         null_access <= addr_req && ind && eff[OPC_ADDR_W-1:0] == '0;
         fsr_wrap <= wrap;
         if (addr_req) ram_file_address <= addr;
         fsr <= fsr_wr_en ? fsr_wr_data : upd ? nxt : fsr;
      end
   end
endmodule
